// File: rtl/state_var_sequencer_pkg.sv
// Shared types for the state-variable sequencer.
// The ST_ERROR encoding exists only when SEQ_TIMEOUT_EN is defined.
package state_var_seq_pkg;

   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_FETCH      = 4'd1,
      ST_COMB_START = 4'd2,
      ST_COMB_WAIT  = 4'd3,
      ST_NORM_START = 4'd4,
      ST_NORM_WAIT  = 4'd5,
      ST_TERM_START = 4'd6,
      ST_TERM_WAIT  = 4'd7,
      ST_WRITE      = 4'd8,
      ST_NEXT_EXPR  = 4'd9,
      ST_NEXT_STEP  = 4'd10,
      ST_DONE       = 4'd11
`ifdef SEQ_TIMEOUT_EN
      ,
      ST_ERROR      = 4'd12
`endif
   } seq_state_e;

   typedef enum logic [1:0] {
      PH_NONE = 2'd0,
      PH_COMB = 2'd1,
      PH_NORM = 2'd2,
      PH_TERM = 2'd3
   } phase_e;

endpackage

// File: rtl/state_var_sequencer_watchdog.sv
// Per-wait-state cycle counter; expired rises in the cycle the count reaches TIMEOUT_CYCLES-1.
// Instantiated by state_var_sequencer only when SEQ_TIMEOUT_EN is defined.
module seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/state_var_sequencer.sv
// Top-level sequencer: fetch initial values, run combination, normalization, then one term
// accumulation per expression with write-back. Define SEQ_TIMEOUT_EN for the wait-state watchdog.
module state_var_sequencer
   import state_var_seq_pkg::*;
#(
   parameter int NUM_INIT_VAL   = 6,
   parameter int NUM_EXPR       = 3,
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int STEP_W         = 8,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int AW = $clog2(NUM_INIT_VAL + NUM_EXPR),
   localparam int EW = (NUM_EXPR > 1) ? $clog2(NUM_EXPR) : 1
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [STEP_W-1:0]                      num_steps,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   error,
   output logic [AW-1:0]                          mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]                  mem_rd_data,
   output logic [AW-1:0]                          mem_wr_addr,
   output logic [DATA_WIDTH-1:0]                  mem_wr_data,
   output logic                                   mem_wr_we,
   output logic [NUM_INIT_VAL-1:0][DATA_WIDTH-1:0] init_val,
   output logic                                   comb_start,
   input  logic                                   comb_done,
   output logic                                   norm_start,
   input  logic                                   norm_done,
   output logic                                   term_start,
   input  logic                                   term_ready,
   input  logic [DATA_WIDTH-1:0]                  term_value,
   output logic [EW-1:0]                          expr_index,
   output logic [1:0]                             phase_sel,
   output logic [3:0]                             state_dbg
);

   // Handshakes: each *_start is a one-cycle Moore strobe; the matching done/ready is
   // level-sampled in the following *_WAIT state, so a done already high on entry is taken.
   seq_state_e                                 state_q, state_d;
   logic [AW-1:0]                              fetch_cnt_q, fetch_cnt_d;
   logic [STEP_W-1:0]                          step_q, step_d;
   logic [STEP_W-1:0]                          step_last_q, step_last_d;
   logic [EW-1:0]                              expr_q, expr_d;
   logic [DATA_WIDTH-1:0]                      wr_data_q, wr_data_d;
   logic [NUM_INIT_VAL-1:0][DATA_WIDTH-1:0]    init_val_q, init_val_d;
   phase_e                                     phase;

`ifdef SEQ_TIMEOUT_EN
   logic wd_clear, wd_enable, wd_expired;

   assign wd_clear  = state_q inside {ST_COMB_START, ST_NORM_START, ST_TERM_START};
   assign wd_enable = state_q inside {ST_COMB_WAIT, ST_NORM_WAIT, ST_TERM_WAIT};

   seq_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock  (clock),
      .reset  (reset),
      .clear  (wd_clear),
      .enable (wd_enable),
      .expired(wd_expired)
   );
`endif

   always_comb begin
      state_d     = state_q;
      fetch_cnt_d = fetch_cnt_q;
      step_d      = step_q;
      step_last_d = step_last_q;
      expr_d      = expr_q;
      wr_data_d   = wr_data_q;
      init_val_d  = init_val_q;

      case (state_q)
`ifdef SEQ_TIMEOUT_EN
         ST_IDLE, ST_ERROR: begin
`else
         ST_IDLE: begin
`endif
            if (start) begin
               state_d     = ST_FETCH;
               fetch_cnt_d = '0;
               step_d      = '0;
               expr_d      = '0;
               step_last_d = (num_steps == '0) ? '0 : num_steps - STEP_W'(1);
            end
         end
         ST_FETCH: begin
            // Read data lags the address by one cycle, so slot i lands when the count is i+1.
            for (int i = 0; i < NUM_INIT_VAL; i++) begin
               if (fetch_cnt_q == AW'(i + 1)) begin
                  init_val_d[i] = mem_rd_data;
               end
            end
            if (fetch_cnt_q == AW'(NUM_INIT_VAL)) begin
               fetch_cnt_d = '0;
               state_d     = ST_COMB_START;
            end else begin
               fetch_cnt_d = fetch_cnt_q + AW'(1);
            end
         end
         ST_COMB_START: state_d = ST_COMB_WAIT;
         ST_COMB_WAIT:  if (comb_done) state_d = ST_NORM_START;
         ST_NORM_START: state_d = ST_NORM_WAIT;
         ST_NORM_WAIT:  if (norm_done) state_d = ST_TERM_START;
         ST_TERM_START: state_d = ST_TERM_WAIT;
         ST_TERM_WAIT: begin
            if (term_ready) begin
               wr_data_d = term_value;
               state_d   = ST_WRITE;
            end
         end
         ST_WRITE: state_d = ST_NEXT_EXPR;
         ST_NEXT_EXPR: begin
            if (expr_q == EW'(NUM_EXPR - 1)) begin
               state_d = ST_NEXT_STEP;
            end else begin
               expr_d  = expr_q + EW'(1);
               state_d = ST_TERM_START;
            end
         end
         ST_NEXT_STEP: begin
            if (step_q == step_last_q) begin
               state_d = ST_DONE;
            end else begin
               step_d  = step_q + STEP_W'(1);
               expr_d  = '0;
               state_d = ST_FETCH;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

`ifdef SEQ_TIMEOUT_EN
      // A handshake in the expiring cycle still wins; expiry only replaces "stay in WAIT".
      if (wd_expired && (state_d == state_q)) begin
         state_d = ST_ERROR;
      end
`endif
   end

   always_comb begin
      busy        = 1'b1;
      done        = 1'b0;
      error       = 1'b0;
      mem_rd_addr = '0;
      mem_wr_addr = '0;
      mem_wr_we   = 1'b0;
      comb_start  = 1'b0;
      norm_start  = 1'b0;
      term_start  = 1'b0;
      phase       = PH_NONE;
      case (state_q)
         ST_IDLE:  busy = 1'b0;
         ST_FETCH: begin
            if (fetch_cnt_q < AW'(NUM_INIT_VAL)) begin
               mem_rd_addr = fetch_cnt_q;
            end
         end
         ST_COMB_START: begin
            comb_start = 1'b1;
            phase      = PH_COMB;
         end
         ST_COMB_WAIT:  phase = PH_COMB;
         ST_NORM_START: begin
            norm_start = 1'b1;
            phase      = PH_NORM;
         end
         ST_NORM_WAIT:  phase = PH_NORM;
         ST_TERM_START: begin
            term_start = 1'b1;
            phase      = PH_TERM;
         end
         ST_TERM_WAIT:  phase = PH_TERM;
         ST_WRITE: begin
            mem_wr_we   = 1'b1;
            mem_wr_addr = AW'(NUM_INIT_VAL) + AW'(expr_q);
         end
         ST_DONE:  done = 1'b1;
`ifdef SEQ_TIMEOUT_EN
         ST_ERROR: begin
            busy  = 1'b0;
            error = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign phase_sel   = phase;
   assign mem_wr_data = wr_data_q;
   assign init_val    = init_val_q;
   assign expr_index  = expr_q;
   assign state_dbg   = state_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         fetch_cnt_q <= '0;
         step_q      <= '0;
         step_last_q <= '0;
         expr_q      <= '0;
         wr_data_q   <= '0;
         init_val_q  <= '0;
      end else begin
         state_q     <= state_d;
         fetch_cnt_q <= fetch_cnt_d;
         step_q      <= step_d;
         step_last_q <= step_last_d;
         expr_q      <= expr_d;
         wr_data_q   <= wr_data_d;
         init_val_q  <= init_val_d;
      end
   end

endmodule

// File: tb/tb_state_var_sequencer.sv
// Self-checking bench for state_var_sequencer: memory and sub-block responders, a write
// scoreboard, and one task per scenario. The timeout scenario runs when SEQ_TIMEOUT_EN is defined.
module tb_state_var_sequencer;
   import state_var_seq_pkg::*;

   localparam int NI = 6;
   localparam int NE = 3;
   localparam int DW = 32;
   localparam int SW = 8;
   localparam int AW = $clog2(NI + NE);
   localparam int EW = (NE > 1) ? $clog2(NE) : 1;

   logic                      clock = 1'b0;
   logic                      reset, start;
   logic [SW-1:0]             num_steps;
   logic                      busy, done, error;
   logic [AW-1:0]             mem_rd_addr, mem_wr_addr;
   logic [DW-1:0]             mem_rd_data, mem_wr_data;
   logic                      mem_wr_we;
   logic [NI-1:0][DW-1:0]     init_val;
   logic                      comb_start, comb_done, norm_start, norm_done;
   logic                      term_start, term_ready;
   logic [DW-1:0]             term_value;
   logic [EW-1:0]             expr_index;
   logic [1:0]                phase_sel;
   logic [3:0]                state_dbg;

   logic [AW+DW-1:0]          exp_q[$];
   logic [AW+DW-1:0]          exp_w;
   logic [DW-1:0]             mem [0:(1<<AW)-1];
   logic [DW-1:0]             init_tbl [0:NI-1];
   logic [DW-1:0]             tv [0:NE-1];
   logic [AW-1:0]             last_rd_addr;

   int n_cmp = 0, n_mis = 0;
   int cyc = 0, n_writes = 0, n_comb = 0, term_seq = 0, t_expr = 0;
   int last_we_cyc = -1, min_gap = 1000, comb_cyc = 0, norm_cyc = 0;
   int c_cnt = -1, n_cnt = -1, t_cnt = -1;
   int cn_lat = 5, term_lat_min = 2, term_lat_max = 2;
   bit comb_hold = 0, norm_never = 0, early = 0, rand_vals = 0, poke_en = 0;

   state_var_sequencer #(
      .NUM_INIT_VAL(NI), .NUM_EXPR(NE), .DATA_WIDTH(DW), .STEP_W(SW), .TIMEOUT_CYCLES(16)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .num_steps(num_steps),
      .busy(busy), .done(done), .error(error),
      .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_we(mem_wr_we),
      .init_val(init_val),
      .comb_start(comb_start), .comb_done(comb_done),
      .norm_start(norm_start), .norm_done(norm_done),
      .term_start(term_start), .term_ready(term_ready), .term_value(term_value),
      .expr_index(expr_index), .phase_sel(phase_sel), .state_dbg(state_dbg)
   );

   // Clock and cycle counter
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Memory (one-cycle read latency) and sub-block responders, driven at the falling edge
   initial begin
      init_tbl[0] = 32'h3F80_0000; init_tbl[1] = 32'h4000_0000; init_tbl[2] = 32'h4040_0000;
      init_tbl[3] = 32'h4080_0000; init_tbl[4] = 32'h40A0_0000; init_tbl[5] = 32'h40C0_0000;
      tv[0] = 32'h3F80_0000; tv[1] = 32'h4000_0000; tv[2] = 32'h4040_0000;
      for (int i = 0; i < (1 << AW); i++) mem[i] = (i < NI) ? init_tbl[i] : '0;
      mem_rd_data = '0; last_rd_addr = '0;
      comb_done = 0; norm_done = 0; term_ready = 0; term_value = '0;
      forever begin
         @(negedge clock);
         mem_rd_data  = mem[last_rd_addr];
         last_rd_addr = mem_rd_addr;
         comb_done = comb_hold; norm_done = 0; term_ready = 0;
         if (reset) begin
            c_cnt = -1; n_cnt = -1; t_cnt = -1;
         end else begin
            if (c_cnt == 0) comb_done = 1;
            if (c_cnt >= 0) c_cnt--;
            if (n_cnt == 0) norm_done = 1;
            if (n_cnt >= 0) n_cnt--;
            if (t_cnt == 0) begin
               term_ready = 1;
               term_value = rand_vals ? $urandom : tv[t_expr];
               exp_q.push_back({AW'(NI + t_expr), term_value});
            end
            if (t_cnt >= 0) t_cnt--;
            if (comb_start) c_cnt = cn_lat;
            if (norm_start && !norm_never) n_cnt = cn_lat;
            if (term_start) begin
               t_expr = term_seq % NE;
               term_seq++;
               t_cnt = $urandom_range(term_lat_max, term_lat_min);
               if (early) begin
                  term_ready = 1;
                  term_value = 32'hDEAD_BEEF;
               end
            end
         end
      end
   end

   // Scoreboard / monitor
   initial begin
      forever begin
         @(negedge clock);
         if (mem_wr_we) begin
            n_writes++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_mis++;
               $display("FAIL write_unexpected: addr=%0d data=%h, no write expected", mem_wr_addr, mem_wr_data);
            end else begin
               exp_w = exp_q.pop_front();
               if ({mem_wr_addr, mem_wr_data} !== exp_w) begin
                  n_mis++;
                  $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                           mem_wr_addr, mem_wr_data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
               end
            end
            if (last_we_cyc >= 0) begin
               n_cmp++;
               if (cyc - last_we_cyc < 4) begin
                  n_mis++;
                  $display("FAIL write_gap: got %0d cycles, expected >= 4", cyc - last_we_cyc);
               end
               if (cyc - last_we_cyc < min_gap) min_gap = cyc - last_we_cyc;
            end
            last_we_cyc = cyc;
            mem[mem_wr_addr] = mem_wr_data;
         end
         if (comb_start) begin
            n_comb++;
            comb_cyc = cyc;
            n_cmp++;
            if (phase_sel !== 2'd1) begin
               n_mis++;
               $display("FAIL phase_comb: got %0d, expected 1", phase_sel);
            end
            if (poke_en) mem[0] = 32'h1234_0000 + n_comb;
         end
         if (norm_start) begin
            norm_cyc = cyc;
            n_cmp++;
            if (phase_sel !== 2'd2) begin
               n_mis++;
               $display("FAIL phase_norm: got %0d, expected 2", phase_sel);
            end
         end
         if (term_start) begin
            n_cmp++;
            if (phase_sel !== 2'd3) begin
               n_mis++;
               $display("FAIL phase_term: got %0d, expected 3", phase_sel);
            end
         end
      end
   end

   // One complete run: start pulse, latency to comb_start, wait for done, per-run counts
   task automatic do_run(input logic [SW-1:0] steps, input int passes, input bit mid_start);
      int k;
      n_writes = 0; n_comb = 0; term_seq = 0; last_we_cyc = -1;
      @(negedge clock);
      start = 1; num_steps = steps;
      k = 0;
      do begin
         @(negedge clock);
         k++;
         if (k == 1) begin
            start = 0;
            n_cmp++;
            if (busy !== 1'b1 || error !== 1'b0) begin
               n_mis++;
               $display("FAIL busy_after_start: got busy=%b error=%b, expected busy=1 error=0", busy, error);
            end
         end
      end while (comb_start !== 1'b1 && k < 50);
      n_cmp++;
      if (k != NI + 2) begin
         n_mis++;
         $display("FAIL start_to_comb: got %0d cycles, expected %0d", k, NI + 2);
      end
      if (mid_start) begin
         k = 0;
         while (term_start !== 1'b1 && k < 200) begin @(negedge clock); k++; end
         @(negedge clock); start = 1;
         @(negedge clock); start = 0;
      end
      k = 0;
      while (done !== 1'b1 && k < 5000) begin @(negedge clock); k++; end
      n_cmp++;
      if (done !== 1'b1) begin
         n_mis++;
         $display("FAIL done_timeout: got no done within %0d cycles, expected done", k);
      end
      n_cmp++;
      if (busy !== 1'b1 || phase_sel !== 2'd0) begin
         n_mis++;
         $display("FAIL done_state: got busy=%b phase=%0d, expected busy=1 phase=0", busy, phase_sel);
      end
      n_cmp++;
      if (n_writes != NE * passes || n_comb != passes || exp_q.size() != 0) begin
         n_mis++;
         $display("FAIL run_counts: got writes=%0d passes=%0d pending=%0d, expected writes=%0d passes=%0d pending=0",
                  n_writes, n_comb, exp_q.size(), NE * passes, passes);
      end
      @(negedge clock);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_mis++;
         $display("FAIL after_done: got done=%b busy=%b, expected 0 0", done, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1; start = 0; num_steps = '0;
      repeat (3) @(negedge clock);
      reset = 0;
      @(negedge clock);
      n_cmp++;
      if ({busy, done, error, mem_wr_we, comb_start, norm_start, term_start} !== 7'b0 ||
          phase_sel !== 2'd0 || state_dbg !== 4'd0) begin
         n_mis++;
         $display("FAIL reset_ctrl: got busy=%b done=%b err=%b we=%b phase=%0d state=%0d, expected all 0",
                  busy, done, error, mem_wr_we, phase_sel, state_dbg);
      end
      n_cmp++;
      if (mem_rd_addr !== '0 || mem_wr_addr !== '0 || mem_wr_data !== '0 ||
          init_val !== '0 || expr_index !== '0) begin
         n_mis++;
         $display("FAIL reset_data: got rd=%0d wr=%0d wdata=%h expr=%0d, expected all 0",
                  mem_rd_addr, mem_wr_addr, mem_wr_data, expr_index);
      end
   endtask

   task automatic test_single_step();
      do_run(8'd1, 1, 1'b0);
      for (int i = 0; i < NI; i++) begin
         n_cmp++;
         if (init_val[i] !== init_tbl[i]) begin
            n_mis++;
            $display("FAIL init_val[%0d]: got %h, expected %h", i, init_val[i], init_tbl[i]);
         end
      end
   endtask

   task automatic test_multi_step();
      rand_vals = 1; term_lat_min = 0; term_lat_max = 6; poke_en = 1;
      do_run(8'd3, 3, 1'b0);
      n_cmp++;
      if (init_val[0] !== 32'h1234_0002) begin
         n_mis++;
         $display("FAIL refetch: got %h, expected %h", init_val[0], 32'h1234_0002);
      end
      poke_en = 0; mem[0] = init_tbl[0];
      do_run(8'd0, 1, 1'b0);
   endtask

   task automatic test_comb_hold();
      rand_vals = 0; term_lat_min = 2; term_lat_max = 2; comb_hold = 1;
      do_run(8'd1, 1, 1'b1);
      comb_hold = 0;
      n_cmp++;
      if (norm_cyc - comb_cyc != 2) begin
         n_mis++;
         $display("FAIL comb_hold: got %0d cycles comb_start->norm_start, expected 2", norm_cyc - comb_cyc);
      end
   endtask

   task automatic test_early_ready();
      early = 1; rand_vals = 1; term_lat_min = 1; term_lat_max = 3;
      do_run(8'd2, 2, 1'b0);
      early = 0;
   endtask

   task automatic test_back_to_back();
      term_lat_min = 0; term_lat_max = 0; min_gap = 1000;
      do_run(8'd2, 2, 1'b0);
      do_run(8'd1, 1, 1'b0);
      n_cmp++;
      if (min_gap != 4) begin
         n_mis++;
         $display("FAIL min_write_gap: got %0d, expected 4", min_gap);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      rand_vals = 0; term_lat_min = 30; term_lat_max = 30;
      n_writes = 0; term_seq = 0; last_we_cyc = -1;
      @(negedge clock); start = 1; num_steps = 8'd1;
      @(negedge clock); start = 0;
      k = 0;
      while (term_seq < 2 && k < 500) begin @(negedge clock); k++; end
      repeat (3) @(negedge clock);
      reset = 1;
      @(negedge clock);
      reset = 0;
      n_cmp++;
      if ({busy, done, error, mem_wr_we, comb_start, norm_start, term_start} !== 7'b0 ||
          phase_sel !== 2'd0 || state_dbg !== 4'd0 || expr_index !== '0 ||
          mem_wr_data !== '0 || init_val !== '0 || mem_wr_addr !== '0) begin
         n_mis++;
         $display("FAIL reset_mid: got busy=%b we=%b phase=%0d state=%0d expr=%0d wdata=%h, expected all 0",
                  busy, mem_wr_we, phase_sel, state_dbg, expr_index, mem_wr_data);
      end
      repeat (40) @(negedge clock);
      n_cmp++;
      if (n_writes != 1 || exp_q.size() != 0) begin
         n_mis++;
         $display("FAIL reset_mid_writes: got %0d writes pending=%0d, expected 1 write pending=0",
                  n_writes, exp_q.size());
      end
      term_lat_min = 2; term_lat_max = 2;
   endtask

`ifdef SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int k;
      norm_never = 1;
      @(negedge clock); start = 1; num_steps = 8'd1;
      @(negedge clock); start = 0;
      k = 0;
      while (norm_start !== 1'b1 && k < 100) begin @(negedge clock); k++; end
      repeat (16) @(negedge clock);
      n_cmp++;
      if (error !== 1'b0 || phase_sel !== 2'd2) begin
         n_mis++;
         $display("FAIL timeout_early: got error=%b phase=%0d, expected 0 2", error, phase_sel);
      end
      @(negedge clock);
      n_cmp++;
      if (error !== 1'b1 || busy !== 1'b0 || phase_sel !== 2'd0) begin
         n_mis++;
         $display("FAIL timeout_error: got error=%b busy=%b phase=%0d, expected 1 0 0", error, busy, phase_sel);
      end
      norm_never = 0;
      do_run(8'd1, 1, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_single_step();
      test_multi_step();
      test_comb_hold();
      test_early_ready();
      test_back_to_back();
      test_reset_mid();
`ifdef SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
